// File: rtl/sinfonia_pkg.sv
// Shared definitions for the melody player: state encoding,
// the silent note code and the default note/gap timing.
package sinfonia_pkg;

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        LE_MEMORIA = 3'd1,
        TOCA       = 3'd2,
        PAUSA      = 3'd3,
        FIM        = 3'd4
    } estado_t;

    localparam int NOTA_SILENCIO      = 0;
    localparam int NOTE_CYCLES_PADRAO = 50_000_000;
    localparam int GAP_CYCLES_PADRAO  = 12_500_000;

    // Timer must hold the larger of the two reload values, never 0 bits wide.
    function automatic int largura_timer(input int n, input int g);
        int m;
        m = (n > g) ? n : g;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/temporizador_nota.sv
// Loadable down-counter that times notes and gaps; it
// rests at zero until reloaded.
module temporizador_nota #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         carrega,
    input  logic [W-1:0] valor,
    output logic         zero
);

    logic [W-1:0] conta_q;
    logic [W-1:0] conta_d;

    always_comb begin
        conta_d = conta_q;
        if (carrega) begin
            conta_d = valor;
        end else if (conta_q != '0) begin
            conta_d = conta_q - W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conta_q <= '0;
        end else begin
            conta_q <= conta_d;
        end
    end

    assign zero = (conta_q == '0);

endmodule

// File: rtl/sequenciador_melodia.sv
// Plays note memory entries 0..limit through the buzzer
// interface, with a start/finish handshake towards game control.
module sequenciador_melodia
    import sinfonia_pkg::*;
#(
    parameter int NOTE_CYCLES = NOTE_CYCLES_PADRAO,
    parameter int GAP_CYCLES  = GAP_CYCLES_PADRAO,
    parameter int ADDR_W      = 4,
    parameter int NOTE_W      = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              abortar,
    input  logic [ADDR_W-1:0] limite,
    output logic [ADDR_W-1:0] mem_endereco,
    input  logic [NOTE_W-1:0] mem_dado,
    output logic [NOTE_W-1:0] arduino_out,
    output logic              arduino_ativo,
    output logic              ocupado,
    output logic              fim,
    output logic [2:0]        db_estado
);

    localparam int TW = largura_timer(NOTE_CYCLES, GAP_CYCLES);
    localparam logic [TW-1:0] CARGA_NOTA  = TW'(NOTE_CYCLES - 1);
    localparam logic [TW-1:0] CARGA_PAUSA = TW'(GAP_CYCLES - 1);
    localparam logic [NOTE_W-1:0] SILENCIO = NOTE_W'(NOTA_SILENCIO);

    estado_t           estado_q;
    estado_t           estado_d;
    logic [ADDR_W-1:0] endereco_q;
    logic [ADDR_W-1:0] endereco_d;
    logic [ADDR_W-1:0] lim_q;
    logic [ADDR_W-1:0] lim_d;
    logic [NOTE_W-1:0] nota_q;
    logic [NOTE_W-1:0] nota_d;
    logic              ativo_q;
    logic              ativo_d;

    logic              timer_zero;
    logic              timer_carrega;
    logic [TW-1:0]     timer_valor;
    logic              ultima;

    assign ultima = (endereco_q == lim_q);

    temporizador_nota #(
        .W (TW)
    ) u_temporizador (
        .clock   (clock),
        .reset   (reset),
        .carrega (timer_carrega),
        .valor   (timer_valor),
        .zero    (timer_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        if (abortar) begin
            estado_d = OCIOSO;
        end else begin
            unique case (estado_q)
                OCIOSO: begin
                    if (iniciar) estado_d = LE_MEMORIA;
                end
                LE_MEMORIA: estado_d = TOCA;
                TOCA: begin
                    if (timer_zero) estado_d = PAUSA;
                end
                PAUSA: begin
                    if (timer_zero) begin
                        estado_d = ultima ? FIM : LE_MEMORIA;
                    end
                end
                FIM:     estado_d = OCIOSO;
                default: estado_d = OCIOSO;
            endcase
        end
    end

    // Buzzer outputs are registered, so they follow the state being entered.
    always_comb begin
        endereco_d = endereco_q;
        lim_d      = lim_q;
        nota_d     = nota_q;
        ativo_d    = ativo_q;
        if (abortar) begin
            nota_d  = SILENCIO;
            ativo_d = 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (iniciar) begin
                        lim_d      = limite;
                        endereco_d = '0;
                    end
                end
                LE_MEMORIA: begin
                    nota_d  = mem_dado;
                    ativo_d = 1'b1;
                end
                TOCA: begin
                    if (timer_zero) begin
                        nota_d  = SILENCIO;
                        ativo_d = 1'b0;
                    end
                end
                PAUSA: begin
                    if (timer_zero && !ultima) begin
                        endereco_d = endereco_q + ADDR_W'(1);
                    end
                end
                default: begin
                    nota_d  = SILENCIO;
                    ativo_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco_q <= '0;
            lim_q      <= '0;
            nota_q     <= '0;
            ativo_q    <= 1'b0;
        end else begin
            endereco_q <= endereco_d;
            lim_q      <= lim_d;
            nota_q     <= nota_d;
            ativo_q    <= ativo_d;
        end
    end

    always_comb begin
        ocupado       = (estado_q != OCIOSO);
        fim           = (estado_q == FIM);
        db_estado     = estado_q;
        timer_carrega = (estado_q == LE_MEMORIA)
                      || ((estado_q == TOCA) && timer_zero);
        timer_valor   = (estado_q == TOCA) ? CARGA_PAUSA : CARGA_NOTA;
    end

    assign mem_endereco  = endereco_q;
    assign arduino_out   = nota_q;
    assign arduino_ativo = ativo_q;

endmodule

// File: tb/tb_sequenciador_melodia.sv
// Bench for sequenciador_melodia: per-cycle comparison against
// a schedule computed from note index and phase arithmetic.
module tb_sequenciador_melodia;

    localparam int N = 4;
    localparam int G = 2;
    localparam int P = 1 + N + G;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       abortar = 1'b0;
    logic [3:0] limite = '0;
    logic [3:0] mem_endereco;
    logic [2:0] mem_dado;
    logic [2:0] arduino_out;
    logic       arduino_ativo;
    logic       ocupado;
    logic       fim;
    logic [2:0] db_estado;

    logic [2:0] mem [16];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign mem_dado = mem[mem_endereco];

    sequenciador_melodia #(
        .NOTE_CYCLES (N),
        .GAP_CYCLES  (G),
        .ADDR_W      (4),
        .NOTE_W      (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .abortar       (abortar),
        .limite        (limite),
        .mem_endereco  (mem_endereco),
        .mem_dado      (mem_dado),
        .arduino_out   (arduino_out),
        .arduino_ativo (arduino_ativo),
        .ocupado       (ocupado),
        .fim           (fim),
        .db_estado     (db_estado)
    );

    task automatic cmp(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // addr < 0 means the address is not defined at this point
    task automatic confere(input string tag, input int addr,
                           input int nota, input int ativo, input int est);
        if (addr >= 0) cmp({tag, ".endereco"}, 8'(mem_endereco), 8'(addr));
        cmp({tag, ".out"},     8'(arduino_out),   8'(nota));
        cmp({tag, ".ativo"},   8'(arduino_ativo), 8'(ativo));
        cmp({tag, ".ocupado"}, 8'(ocupado),       8'(est != 0));
        cmp({tag, ".fim"},     8'(fim),           8'(est == 4));
        cmp({tag, ".estado"},  8'(db_estado),     8'(est));
    endtask

    // k counts cycles from the one after iniciar was accepted
    function automatic void modelo(input int k, input int lim,
                                   output int est, output int addr,
                                   output int nota, output int ativo);
        int total;
        int i;
        int p;
        total = (lim + 1) * P;
        nota  = 0;
        ativo = 0;
        addr  = lim;
        est   = 0;
        if (k < total) begin
            i    = k / P;
            p    = k % P;
            addr = i;
            if (p == 0) begin
                est = 1;
            end else if (p <= N) begin
                est   = 2;
                nota  = int'(mem[i]);
                ativo = 1;
            end else begin
                est = 3;
            end
        end else if (k == total) begin
            est = 4;
        end
    endfunction

    task automatic sequencia(input int lim, input int k_abort,
                             input int k_ruido, input int k_reset,
                             input string nome);
        int total;
        int est;
        int addr;
        int nota;
        int ativo;
        int modo;
        total = (lim + 1) * P;
        modo  = 0;
        @(negedge clock);
        limite  = 4'(lim);
        iniciar = 1'b1;
        @(posedge clock);
        #1;
        iniciar = 1'b0;
        limite  = 4'($urandom);
        for (int k = 0; k <= total + 2; k++) begin
            @(negedge clock);
            if (modo == 0) begin
                modelo(k, lim, est, addr, nota, ativo);
            end else begin
                est   = 0;
                nota  = 0;
                ativo = 0;
                addr  = (modo == 2) ? 0 : -1;
            end
            confere(nome, addr, nota, ativo, est);
            iniciar = 1'b0;
            abortar = 1'b0;
            if (modo == 0 && k == k_abort) begin
                abortar = 1'b1;
                modo    = 1;
            end
            if (modo == 0 && k == k_ruido) begin
                iniciar = 1'b1;
                limite  = 4'd0;
            end
            if (modo == 0 && k == k_reset) begin
                #2 reset = 1'b0;
                #1 confere({nome, ".assincrono"}, 0, 0, 0, 0);
                #1 reset = 1'b1;
                modo = 2;
            end
        end
        iniciar = 1'b0;
        abortar = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 3'd0;
        mem[0] = 3'd5;
        mem[1] = 3'd3;
        mem[2] = 3'd7;
        mem[3] = 3'd1;

        #1 confere("reset", 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        confere("pos_reset", 0, 0, 0, 0);

        sequencia(0, -1, -1, -1, "lim0");
        sequencia(3, -1, -1, -1, "lim3");
        sequencia(3, P + 2, -1, -1, "abort");
        sequencia(0, -1, -1, -1, "reinicio");

        @(negedge clock);
        abortar = 1'b1;
        iniciar = 1'b1;
        limite  = 4'd3;
        @(negedge clock);
        abortar = 1'b0;
        iniciar = 1'b0;
        confere("abort_iniciar", -1, 0, 0, 0);
        @(negedge clock);
        confere("abort_iniciar2", -1, 0, 0, 0);

        sequencia(3, -1, 10, -1, "ruido");
        sequencia(3, -1, 4 * P, -1, "ruido_fim");
        sequencia(3, -1, -1, P + 5, "reset_pausa");

        mem[1] = 3'd0;
        sequencia(1, -1, -1, -1, "silencio");

        for (int r = 0; r < 6; r++) begin
            int lim;
            for (int i = 0; i < 16; i++) mem[i] = 3'($urandom_range(0, 7));
            lim = (r == 0) ? 15 : int'($urandom_range(0, 15));
            sequencia(lim, -1, -1, -1, "aleatorio");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
